// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and the per-frame mode bits.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    TRANSFER,
    TRAIL,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic loopback;
  } spi_cfg_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period down-counter: ticks every div+1 clk cycles while running and toggles sclk on enabled ticks.
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 toggle_en,
  input  logic                 idle_level,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= div;
      sclk <= idle_level;
    end else if (tick) begin
      cnt <= div;
      if (toggle_en) sclk <= ~sclk;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with CPOL/CPHA modes, bit order, runtime divider, inter-frame gap, loopback.
// state    | meaning
// IDLE     | cs_bar high, sclk follows cpol input, waiting for start
// LEAD     | cs_bar low, sclk at CPOL for one half-period
// TRANSFER | 2*DATA_WIDTH half-periods, sclk toggling between them
// TRAIL    | sclk back at CPOL for one half-period before release
// GAP      | cs_bar high, busy held for the latched gap count
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int GAP_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  loopback,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_bar,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_done
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(EDGES + 1);
  localparam int IW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  spi_state_t            state;
  spi_cfg_t              cfg;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [EW-1:0]         edge_cnt;
  logic                  done_q;

  logic                  tick, run, toggle_en, idle_level, last_tick;
  logic [DIV_WIDTH-1:0]  div_sel;
  logic [EW-1:0]         edge_next;
  logic [IW-1:0]         bit_idx;
  logic                  is_lead, do_sample, do_shift, out_bit, rx_bit, first_bit;

  // edge_cnt counts sclk toggles done; the tick after the last toggle closes TRANSFER without toggling
  always_comb begin
    run        = (state == LEAD) || (state == TRANSFER) || (state == TRAIL);
    last_tick  = (state == TRANSFER) && (edge_cnt == EW'(EDGES));
    toggle_en  = (state == LEAD) || ((state == TRANSFER) && !last_tick);
    idle_level = (state == IDLE) ? cpol : cfg.cpol;
    div_sel    = (state == IDLE) ? clk_div : div_q;
    edge_next  = edge_cnt + 1'b1;
    is_lead    = edge_next[0];
    do_sample  = cfg.cpha ? !is_lead : is_lead;
    do_shift   = cfg.cpha ? is_lead : (!is_lead && (edge_next != EW'(EDGES)));
    bit_idx    = IW'(edge_next >> 1);
    out_bit    = cfg.lsb_first ? tx_word[bit_idx] : tx_word[IW'(DATA_WIDTH - 1) - bit_idx];
    rx_bit     = cfg.loopback ? mosi : miso;
    first_bit  = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
  end

  spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .toggle_en  (toggle_en),
    .idle_level (idle_level),
    .div        (div_sel),
    .tick       (tick),
    .sclk       (sclk)
  );

  assign rx_valid = done_q;
  assign tx_done  = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cfg      <= '0;
      tx_word  <= '0;
      rx_shift <= '0;
      div_q    <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      edge_cnt <= '0;
      mosi     <= 1'b0;
      cs_bar   <= 1'b1;
      busy     <= 1'b0;
      rx_data  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          cs_bar <= 1'b1;
          mosi   <= 1'b0;
          if (start) begin
            cfg      <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first, loopback: loopback};
            tx_word  <= tx_data;
            div_q    <= clk_div;
            gap_q    <= gap;
            edge_cnt <= '0;
            rx_shift <= '0;
            cs_bar   <= 1'b0;
            busy     <= 1'b1;
            mosi     <= cpha ? 1'b0 : first_bit;
            state    <= LEAD;
          end
        end
        LEAD, TRANSFER: begin
          if (tick) begin
            if (last_tick) begin
              state <= TRAIL;
            end else begin
              edge_cnt <= edge_next;
              if (do_sample)
                rx_shift <= cfg.lsb_first ? {rx_bit, rx_shift[DATA_WIDTH-1:1]}
                                          : {rx_shift[DATA_WIDTH-2:0], rx_bit};
              if (do_shift) mosi <= out_bit;
              if (state == LEAD) state <= TRANSFER;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            cs_bar  <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_shift;
            done_q  <= 1'b1;
            if (gap_q != '0) begin
              gap_cnt <= gap_q - 1'b1;
              state   <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: vector table of single frames against a mode-aware slave
// model, plus sequences for back-to-back frames, mid-frame reset and mid-frame config changes.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        reset, start, cpol, cpha, lsb_first, loopback, miso;
  logic [15:0] tx_data;
  logic [7:0]  clk_div;
  logic [5:0]  gap;
  logic        sclk, mosi, cs_bar, busy, rx_valid, tx_done;
  logic [15:0] rx_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_WIDTH(16), .DIV_WIDTH(8), .GAP_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .loopback(loopback),
    .clk_div(clk_div), .gap(gap), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs_bar(cs_bar), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave model: reacts on the falling clk edge to cs_bar/sclk changes in its own configured mode
  logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [15:0] s_tx = 16'h0, s_rx = 16'h0;
  int          out_idx = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  function automatic logic sbit(input int i);
    return s_lsb ? s_tx[i] : s_tx[15-i];
  endfunction

  always @(negedge clk) begin
    logic lead;
    if (cs_bar !== 1'b0) begin
      miso = 1'b0;
    end else if (prev_cs === 1'b1) begin
      s_rx = 16'h0;
      if (!s_cpha) begin
        miso = sbit(0);
        out_idx = 1;
      end else begin
        out_idx = 0;
      end
    end else if (sclk !== prev_sclk) begin
      lead = (sclk != s_cpol);
      if (lead ^ s_cpha) begin
        s_rx = s_lsb ? {mosi, s_rx[15:1]} : {s_rx[14:0], mosi};
      end else if (out_idx < 16) begin
        miso = sbit(out_idx);
        out_idx++;
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs_bar;
  end

  typedef struct {
    logic        cpol, cpha, lsb, loop;
    logic [7:0]  div;
    logic [15:0] tx, stx, exp_rx, exp_srx;
    logic        perturb;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int j, lowcnt, exp_len;
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; loopback = v.loop;
    clk_div = v.div; gap = 6'd0; tx_data = v.tx;
    s_cpol = v.cpol; s_cpha = v.cpha; s_lsb = v.lsb; s_tx = v.stx;
    @(negedge clk);
    check("idle_sclk", {31'd0, sclk}, {31'd0, v.cpol});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy_cs", {30'd0, busy, cs_bar}, 32'd2);
    exp_len = (int'(v.div) + 1) * 34;
    j = 0;
    lowcnt = 0;
    while (rx_valid !== 1'b1 && j < 2000) begin
      if (cs_bar === 1'b0) lowcnt++;
      if (v.perturb && j == 5) begin
        clk_div = 8'd7; tx_data = 16'h0000; cpol = ~v.cpol; lsb_first = ~v.lsb;
      end
      @(posedge clk); #1;
      j++;
    end
    if (j >= 2000) begin
      failures++;
      checks++;
      $display("FAIL frame_timeout actual=%0d required=%0d", j, exp_len);
      return;
    end
    check("cs_low_len", lowcnt, exp_len);
    check("done_time", j, exp_len);
    check("rx_data", rx_data, v.exp_rx);
    check("tx_done_with_valid", {31'd0, tx_done}, 32'd1);
    check("end_sclk", {31'd0, sclk}, {31'd0, v.cpol});
    @(negedge clk);
    check("slave_rx", s_rx, v.exp_srx);
    @(posedge clk); #1;
    check("pulse_len", {31'd0, rx_valid}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int j, hc, lowcnt, vcnt;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'hA5C3, 16'h3C5A, 16'h3C5A, 16'hA5C3, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 16'h8001, 16'h1234, 16'h1234, 16'h8001, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 16'h8001, 16'hBEEF, 16'hBEEF, 16'h8001, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 16'h8001, 16'h0F0F, 16'h0F0F, 16'h8001, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 16'h0F12, 16'hFFFF, 16'h0F12, 16'h0F12, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 16'h1357, 16'h9ABC, 16'h9ABC, 16'h1357, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 16'hA5C3, 16'h6C6C, 16'h6C6C, 16'hA5C3, 1'b1};

    reset = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; loopback = 1'b0;
    tx_data = 16'h0; clk_div = 8'd0; gap = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, sclk, mosi, cs_bar, busy, rx_valid, tx_done}, 32'b001000);
    check("reset_rx_data", rx_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-to-back frames with start held and gap=5, then stray start pulses while busy
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loopback = 1'b0;
    clk_div = 8'd0; gap = 6'd5; tx_data = 16'h00FF;
    s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_tx = 16'h5555;
    start = 1'b1;
    j = 0;
    while (rx_valid !== 1'b1 && j < 500) begin @(posedge clk); #1; j++; end
    check("b2b_first_done", {31'd0, rx_valid}, 32'd1);
    hc = 0;
    while (cs_bar === 1'b1 && hc < 100) begin @(posedge clk); #1; hc++; end
    check("b2b_cs_high_len", hc, 6);
    start = 1'b0;
    j = 0;
    while (rx_valid !== 1'b1 && j < 500) begin
      if (j == 3 || j == 10 || j == 20) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0;
    check("b2b_second_rx", rx_data, 16'h5555);
    lowcnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (cs_bar !== 1'b1) lowcnt++;
    end
    check("no_extra_frame", lowcnt, 0);
    check("idle_after_gap", {31'd0, busy}, 32'd0);

    // Reset in the middle of a frame, around bit 7
    @(negedge clk);
    gap = 6'd0; clk_div = 8'd1; tx_data = 16'h1111; s_tx = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", {27'd0, sclk, cs_bar, busy, rx_valid, tx_done}, 32'b01000);
    check("midreset_rx_data", rx_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    vcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (rx_valid !== 1'b0 || cs_bar !== 1'b1) vcnt++;
    end
    check("midreset_no_done", vcnt, 0);

    run_frame(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
